pwm_duty_meter: RTL and testbench

Measures an incoming PWM waveform, reporting period, high time and normalised duty cycle in system-clock cycles. It is the receive-side counterpart of the on-board PWM/breathing-LED generators, used to close the loop in self-test and to decode external PWM control inputs. Input is asynchronous and is synchronised internally. Results are published with a single-cycle valid strobe once per completed period.

---
 rtl/pwm_duty_meter.sv | 233 +++++++++++++++++++++++
 tb/tb_pwm_duty_meter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_meter.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_duty_meter
//  Function : Measures an asynchronous PWM input. Publishes period, high time
//             and normalised duty once per completed rise-to-rise period,
//             flags a stuck input and reports dropped measurements.
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_duty_meter #(
    parameter int CNT_W   = 20,
    parameter int DUTY_W  = 10,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwm_in,
    output logic [CNT_W-1:0]  period,
    output logic [CNT_W-1:0]  high_time,
    output logic [DUTY_W-1:0] duty,
    output logic              valid,
    output logic              stuck,
    output logic              stuck_level,
    output logic              overrun
);

    localparam int               DC_W        = $clog2(DUTY_W + 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_AGE_TRIP  = CNT_W'(TIMEOUT - 1);
    localparam logic [DC_W-1:0]  C_DIV_STEPS = DC_W'(DUTY_W);
    localparam logic [DC_W-1:0]  C_DIV_ONE   = DC_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    // synchroniser and edge detect
    logic sync1_q, sync1_d, sync2_q, sync2_d, dly_q, dly_d;
    // measurement
    state_t           state_q, state_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d, lo_cnt_q, lo_cnt_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] edge_age_q, edge_age_d;
    logic             stuck_q, stuck_d, stuck_level_q, stuck_level_d;
    logic             overrun_q, overrun_d;
    // divider
    logic              div_busy_q, div_busy_d;
    logic [DC_W-1:0]   div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0]  div_rem_q, div_rem_d;
    logic [CNT_W-1:0]  div_p_q, div_p_d, div_h_q, div_h_d;
    logic [DUTY_W-1:0] div_quo_q, div_quo_d;
    // published results
    logic [CNT_W-1:0]  period_q, period_d, high_time_q, high_time_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              valid_q, valid_d;

    logic              w_rise, w_fall, w_edge, w_div_idle, w_div_start, w_ge;
    logic [CNT_W:0]    w_per_sum, w_shift, w_diff;
    logic [DUTY_W-1:0] w_quo_next;

    assign w_rise     = sync2_q & ~dly_q;
    assign w_fall     = ~sync2_q & dly_q;
    assign w_edge     = w_rise | w_fall;
    assign w_per_sum  = {1'b0, hi_cnt_q} + {1'b0, lo_cnt_q};
    // The divider counts as busy through its valid cycle as well.
    assign w_div_idle = ~div_busy_q & ~valid_q;

    // Restoring step: remainder is always below p, so the borrow bit decides.
    assign w_shift    = {div_rem_q, 1'b0};
    assign w_diff     = w_shift - {1'b0, div_p_q};
    assign w_ge       = ~w_diff[CNT_W];
    assign w_quo_next = (div_quo_q << 1) | DUTY_W'(w_ge);

    // Synchroniser, edge-age timer and measurement state machine next-state
    always_comb begin
        sync1_d       = pwm_in;
        sync2_d       = sync1_q;
        dly_d         = sync2_q;
        state_d       = state_q;
        hi_cnt_d      = hi_cnt_q;
        lo_cnt_d      = lo_cnt_q;
        sat_d         = sat_q;
        edge_age_d    = edge_age_q;
        stuck_d       = stuck_q;
        stuck_level_d = stuck_level_q;
        overrun_d     = 1'b0;
        w_div_start   = 1'b0;

        if (w_edge) begin
            edge_age_d = '0;
            stuck_d    = 1'b0;
        end else if (edge_age_q != C_CNT_MAX) begin
            edge_age_d = edge_age_q + C_CNT_ONE;
        end

        case (state_q)
            ST_IDLE: begin
                if (w_rise) begin
                    state_d  = ST_HIGH;
                    hi_cnt_d = C_CNT_ONE;
                    lo_cnt_d = '0;
                    sat_d    = 1'b0;
                end
            end
            default: begin
                if (w_rise) begin
                    // Completing rise: hand off the sample unless saturated.
                    if (state_q == ST_LOW && !sat_q) begin
                        if (w_div_idle) begin
                            w_div_start = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                    state_d  = ST_HIGH;
                    hi_cnt_d = C_CNT_ONE;
                    lo_cnt_d = '0;
                    sat_d    = 1'b0;
                end else if (!w_fall && edge_age_q == C_AGE_TRIP) begin
                    state_d       = ST_IDLE;
                    stuck_d       = 1'b1;
                    stuck_level_d = sync2_q;
                end else begin
                    if (w_per_sum == {1'b0, C_CNT_MAX}) begin
                        sat_d = 1'b1;
                    end else if (state_q == ST_HIGH && !w_fall) begin
                        hi_cnt_d = hi_cnt_q + C_CNT_ONE;
                    end else begin
                        lo_cnt_d = lo_cnt_q + C_CNT_ONE;
                    end
                    if (state_q == ST_HIGH && w_fall) begin
                        state_d = ST_LOW;
                    end
                end
            end
        endcase
    end

    // Duty divider and result publication next-state
    always_comb begin
        div_busy_d  = div_busy_q;
        div_cnt_d   = div_cnt_q;
        div_rem_d   = div_rem_q;
        div_p_d     = div_p_q;
        div_h_d     = div_h_q;
        div_quo_d   = div_quo_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        duty_d      = duty_q;
        valid_d     = 1'b0;

        if (w_div_start) begin
            div_busy_d = 1'b1;
            div_cnt_d  = C_DIV_STEPS;
            div_rem_d  = hi_cnt_q;
            div_p_d    = w_per_sum[CNT_W-1:0];
            div_h_d    = hi_cnt_q;
            div_quo_d  = '0;
        end else if (div_busy_q) begin
            div_rem_d = w_ge ? w_diff[CNT_W-1:0] : w_shift[CNT_W-1:0];
            div_quo_d = w_quo_next;
            div_cnt_d = div_cnt_q - C_DIV_ONE;
            if (div_cnt_q == C_DIV_ONE) begin
                div_busy_d  = 1'b0;
                valid_d     = 1'b1;
                period_d    = div_p_q;
                high_time_d = div_h_q;
                duty_d      = w_quo_next;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            dly_q         <= 1'b0;
            state_q       <= ST_IDLE;
            hi_cnt_q      <= '0;
            lo_cnt_q      <= '0;
            sat_q         <= 1'b0;
            edge_age_q    <= '0;
            stuck_q       <= 1'b0;
            stuck_level_q <= 1'b0;
            overrun_q     <= 1'b0;
            div_busy_q    <= 1'b0;
            div_cnt_q     <= '0;
            div_rem_q     <= '0;
            div_p_q       <= '0;
            div_h_q       <= '0;
            div_quo_q     <= '0;
            period_q      <= '0;
            high_time_q   <= '0;
            duty_q        <= '0;
            valid_q       <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            dly_q         <= dly_d;
            state_q       <= state_d;
            hi_cnt_q      <= hi_cnt_d;
            lo_cnt_q      <= lo_cnt_d;
            sat_q         <= sat_d;
            edge_age_q    <= edge_age_d;
            stuck_q       <= stuck_d;
            stuck_level_q <= stuck_level_d;
            overrun_q     <= overrun_d;
            div_busy_q    <= div_busy_d;
            div_cnt_q     <= div_cnt_d;
            div_rem_q     <= div_rem_d;
            div_p_q       <= div_p_d;
            div_h_q       <= div_h_d;
            div_quo_q     <= div_quo_d;
            period_q      <= period_d;
            high_time_q   <= high_time_d;
            duty_q        <= duty_d;
            valid_q       <= valid_d;
        end
    end

    assign period      = period_q;
    assign high_time   = high_time_q;
    assign duty        = duty_q;
    assign valid       = valid_q;
    assign stuck       = stuck_q;
    assign stuck_level = stuck_level_q;
    assign overrun     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_meter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_duty_meter
//  Function : Self-checking bench for pwm_duty_meter. Directed waveforms plus
//             random periods, compared each cycle against an event-level
//             model of the measurement rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_duty_meter;

    localparam int CNT_W   = 12;
    localparam int DUTY_W  = 10;
    localparam int TIMEOUT = 3000;
    localparam int MAXP    = (1 << CNT_W) - 1;
    localparam int NC      = 65536;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              pwm_in = 1'b0;
    logic [CNT_W-1:0]  period, high_time;
    logic [DUTY_W-1:0] duty;
    logic              valid, stuck, stuck_level, overrun;

    pwm_duty_meter #(.CNT_W(CNT_W), .DUTY_W(DUTY_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .pwm_in(pwm_in),
        .period(period), .high_time(high_time), .duty(duty),
        .valid(valid), .stuck(stuck), .stuck_level(stuck_level), .overrun(overrun)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Schedule of visible output events, indexed by cycle.
    bit pin_hist [NC];
    bit s_valid  [NC];
    bit s_ovr    [NC];
    bit s_stset  [NC];
    bit s_stclr  [NC];
    bit s_lvl    [NC];
    int s_p [NC];
    int s_h [NC];
    int s_d [NC];

    int  m_state = 0;      // 0 idle, 1 after rise, 2 after fall
    int  t_rise, t_fall, last_edge;
    int  free_at = 0;
    bit  m_stuck = 0;
    bit  rst_prev = 1;
    int  e_p = 0, e_h = 0, e_d = 0;
    bit  e_stuck = 0, e_lvl = 0;

    function automatic bit pin_at(int c);
        return (c < 0) ? 1'b0 : pin_hist[c];
    endfunction

    task automatic model_reset(int r);
        for (int i = r + 1; i < r + DUTY_W + 4 && i < NC; i++) begin
            s_valid[i] = 0; s_ovr[i] = 0; s_stset[i] = 0; s_stclr[i] = 0;
        end
        m_state = 0; free_at = 0; m_stuck = 0;
    endtask

    // One cycle in the synchronised domain: the input level seen is the pin
    // driven two cycles earlier.
    task automatic model_step(int e);
        bit s, sp, rise, fall;
        int per, hi, v;
        s    = pin_at(e - 2);
        sp   = pin_at(e - 3);
        rise = s & ~sp;
        fall = ~s & sp;
        if (rise || fall) begin
            last_edge = e;
            if (m_stuck) begin m_stuck = 0; s_stclr[e + 1] = 1; end
        end
        if (rise) begin
            if (m_state == 2) begin
                per = e - t_rise;
                hi  = t_fall - t_rise;
                if (per <= MAXP) begin
                    if (e >= free_at) begin
                        v = e + DUTY_W + 1;
                        s_valid[v] = 1;
                        s_p[v] = per;
                        s_h[v] = hi;
                        s_d[v] = int'((longint'(hi) << DUTY_W) / per);
                        free_at = e + DUTY_W + 2;
                    end else begin
                        s_ovr[e + 1] = 1;
                    end
                end
            end
            m_state = 1;
            t_rise  = e;
        end else if (fall) begin
            if (m_state == 1) begin m_state = 2; t_fall = e; end
        end else if (m_state != 0 && e - last_edge == TIMEOUT) begin
            m_state = 0;
            m_stuck = 1;
            s_stset[e + 1] = 1;
            s_lvl[e + 1]   = s;
        end
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        pin_hist[cyc] = pwm_in;
        if (cyc > 0) begin
            if (rst_prev) begin
                e_p = 0; e_h = 0; e_d = 0; e_stuck = 0; e_lvl = 0;
            end
            if (s_valid[cyc]) begin e_p = s_p[cyc]; e_h = s_h[cyc]; e_d = s_d[cyc]; end
            if (s_stset[cyc]) begin e_stuck = 1; e_lvl = s_lvl[cyc]; end
            if (s_stclr[cyc]) e_stuck = 0;
            check("valid",       32'(valid),       32'(s_valid[cyc] & ~rst_prev));
            check("overrun",     32'(overrun),     32'(s_ovr[cyc] & ~rst_prev));
            check("stuck",       32'(stuck),       32'(e_stuck));
            check("stuck_level", 32'(stuck_level), 32'(e_lvl));
            check("period",      32'(period),      32'(e_p));
            check("high_time",   32'(high_time),   32'(e_h));
            check("duty",        32'(duty),        32'(e_d));
        end
        if (rst) model_reset(cyc);
        else     model_step(cyc);
        rst_prev = rst;
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit lvl, input int n);
        @(posedge clk);
        #1 pwm_in = lvl;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic pulses(input int h, input int l, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, h);
            drive(1'b0, l);
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1 begin rst = 1'b1; pwm_in = 1'b0; end
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        drive(1'b0, 10);

        pulses(50, 50, 5);             // 50 % square, period 100
        pulses(250, 750, 3);           // 25 %, period 1000
        drive(1'b1, 250);
        drive(1'b0, 350);
        do_reset(2);                   // abort mid-period
        drive(1'b0, 400);
        pulses(250, 750, 3);

        pulses(100, 100, 3);           // stuck high, then recover
        drive(1'b1, TIMEOUT + 50);
        drive(1'b0, 100);
        pulses(100, 100, 3);

        pulses(3, 3, 20);              // period 6: overruns expected
        drive(1'b0, 20);

        pulses(2500, 2500, 1);         // exceeds counter range
        pulses(50, 150, 3);

        pulses(1, 19, 5);              // single-cycle high pulse

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0)
                pulses($urandom_range(1, 8), $urandom_range(1, 8), 1);
            else
                pulses($urandom_range(1, 250), $urandom_range(1, 250), 1);
        end
        drive(1'b0, 60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
